sha256_msg_padder: RTL and testbench
====================================

Name: sha256_msg_padder

Overview:
Upstream front-end of the sha256 co-processor. On start it reads the message words from the shared word-addressed SRAM and applies SHA-256 pre-processing: a 0x80 pad byte, zero fill, and the 64-bit big-endian bit length. It then streams the padded message to the compression core one 32-bit word at a time over a valid/ready handshake, tagging block and message boundaries.

Parameters:
ADDR_W, 16, SRAM word-address width (width of mem_addr)
SIZE_W, 32, width of size and message_addr

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  level; sampled only in IDLE
message_addr  input  SIZE_W  word address of first message word
size  input  SIZE_W  message length in bytes
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse after last word handshake
mem_clk  output  1  equals clk
mem_we  output  1  tied 0 (read-only master)
mem_addr  output  ADDR_W  SRAM read address
mem_read_data  input  32  SRAM read data, valid the cycle after mem_addr is registered
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts when out_valid & out_ready at rising edge
out_data  output  32  padded message word, big-endian byte order
out_word_idx  output  4  word index within 512-bit block (0..15)
out_block_last  output  1  out_word_idx==15
out_msg_last  output  1  final word of final block

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values: busy=0, done=0, out_valid=0, out_data=0, out_word_idx=0, out_block_last=0, out_msg_last=0, mem_addr=0, mem_we=0. The FSM returns to IDLE.
- Reset mid-operation aborts the current message. No word is emitted after reset deasserts until a new start.
- Latched at start: base=message_addr[ADDR_W-1:0], sz=size.
- Derived values:
  - rd_words = ceil(sz/4).
  - blocks = floor((sz+8)/64)+1.
  - total = 16*blocks.
  - g = global word counter, 0..total-1.
- Word content for index g:
  - g < floor(sz/4): mem[base+g] unchanged.
  - g == floor(sz/4), by sz%4:
    - 0: 0x80000000 (no read)
    - 1: mem & 0xFF000000 | 0x00800000
    - 2: mem & 0xFFFF0000 | 0x00008000
    - 3: mem & 0xFFFFFF00 | 0x00000080
  - Otherwise: 0, except g==total-2 -> sz>>29 and g==total-1 -> (sz<<3) mod 2^32.
  - A memory read occurs only when g < rd_words.
- FSM states:
  - IDLE: start -> latch inputs, busy=1, g=0, go to FETCH.
  - FETCH: if g<rd_words, register mem_addr=base+g and go to WAIT. Otherwise form the word and go to EMIT.
  - WAIT: one cycle; capture mem_read_data with mask/pad applied into out_data; go to EMIT.
  - EMIT: out_valid=1. out_data, out_word_idx, out_block_last and out_msg_last are held stable while out_ready=0. On handshake: if g==total-1, go to DONE; else g++ and go to FETCH.
  - DONE: done=1 for one cycle, busy=0, back to IDLE.
- Timing:
  - out_valid rises no earlier than the 2nd cycle after start for a non-memory word, and the 3rd cycle for a memory word.
  - Throughput: 1 word per 2 cycles (no read) or 3 cycles (read) with out_ready=1.
- Address arithmetic wraps modulo 2^ADDR_W.
- start while busy is ignored. start held high through DONE re-triggers only from IDLE.
- out_ready while out_valid=0 is ignored.

Decomposition:
- Package sha256_pkg holds:
  - padder_state_t enum (IDLE, FETCH, WAIT, EMIT, DONE)
  - PAD_BYTE = 8'h80
  - WORDS_PER_BLOCK = 16
  - function pad_mask(sz[1:0]) returning {mask, pad_word}
- No sub-module needed; a single FSM plus counter is natural.

Test Plan:
- size=0, out_ready=1 -> 16 words; word0=0x80000000, words1..15=0; out_msg_last on word15; no SRAM reads issued.
- size=64, seed 0x01234567 at addr 0 rotated left 1 per word -> 32 words:
  - words0..15 = SRAM data (word0=0x01234567, word1=0x02468ACE)
  - word16=0x80000000
  - word30=0, word31=0x00000200
  - out_block_last on words 15 and 31.
- size=55 -> 16 words; word13 = mem[13] & 0xFFFFFF00 | 0x80; word14=0; word15=0x000001B8; exactly 14 reads.
- size=56 -> 32 words; word14=0x80000000; word31=0x000001C0. size=57 -> word14 = mem[14] & 0xFF000000 | 0x00800000.
- out_ready toggled pseudo-randomly with size=64 -> out_data and tags stable across stalls; sequence identical to the unstalled run; a single done pulse.
- Reset asserted during EMIT at g=5 -> all outputs 0 immediately (asynchronous). A new start with size=0 produces a clean 16-word stream.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared definitions for the sha256 co-processor front-end.
//   padder_state_t : message padder FSM states
//   PAD_BYTE       : first byte appended after the message (0x80)
//   WORDS_PER_BLOCK: 32-bit words per 512-bit block
//   pad_mask()     : for a byte remainder sz[1:0], the mask keeping the
//                    valid leading message bytes of a partial word and the
//                    word carrying the pad byte right after them.
package sha256_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    EMIT,
    DONE
  } padder_state_t;

  localparam logic [7:0] PAD_BYTE = 8'h80;
  localparam int unsigned WORDS_PER_BLOCK = 16;

  typedef struct packed {
    logic [31:0] mask;
    logic [31:0] pad_word;
  } pad_mask_t;

  // Remainder 0 yields mask=0 and pad=0x80000000, so the same result also
  // forms the pad word when the message ends on a word boundary.
  function automatic pad_mask_t pad_mask(input logic [1:0] sz);
    pad_mask_t r;
    r.mask     = ~(32'hFFFF_FFFF >> {sz, 3'b000});
    r.pad_word = {PAD_BYTE, 24'h00_0000} >> {sz, 3'b000};
    return r;
  endfunction

endpackage

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: reads a byte-sized message from a word-addressed
// SRAM, appends 0x80, zero fill and the 64-bit big-endian bit length, and
// streams the padded message one 32-bit word per valid/ready handshake.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   start                begin a message (sampled only when idle)
//   message_addr, size   first word address and byte length of message
//   busy, done           busy from accepted start; done pulses at the end
//   mem_clk, mem_we,
//   mem_addr,
//   mem_read_data        read-only SRAM master (data one cycle after addr)
//   out_valid, out_ready output handshake
//   out_data             padded word, big-endian byte order
//   out_word_idx         word index within the 512-bit block
//   out_block_last       last word of a block
//   out_msg_last         last word of the padded message
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned SIZE_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [SIZE_W-1:0] message_addr,
  input  logic [SIZE_W-1:0] size,
  output logic              busy,
  output logic              done,
  output logic              mem_clk,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_read_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [3:0]        out_word_idx,
  output logic              out_block_last,
  output logic              out_msg_last
);

  // Word counters need SIZE_W-1 bits: the padded length of a maximal
  // message is just over 2^30 words.
  localparam int unsigned GW = SIZE_W - 1;

  padder_state_t     state;
  logic [ADDR_W-1:0] base;
  logic [SIZE_W-1:0] sz;
  logic [GW-1:0]     g;
  logic [GW-1:0]     full_words;
  logic [GW-1:0]     rd_words;
  logic [GW-1:0]     last_g;

  logic [GW-1:0]     st_full;
  logic [GW-1:0]     st_rd;
  logic [SIZE_W-6:0] st_blk;
  logic [GW-1:0]     st_last;

  pad_mask_t         pm;
  logic [31:0]       fill_word;
  logic [31:0]       mem_word;
  logic              tag_block_last;
  logic              tag_msg_last;

  logic [SIZE_W-ADDR_W-1:0] unused_addr_hi;

  assign mem_clk        = clk;
  assign mem_we         = 1'b0;
  assign unused_addr_hi = message_addr[SIZE_W-1:ADDR_W];

  // floor((sz+8)/64) is computed as floor(sz/64) + (sz%64 >= 56) so no
  // intermediate exceeds SIZE_W bits; total-1 is then {blocks-1, 4'hF}.
  always_comb begin
    st_full = {1'b0, size[SIZE_W-1:2]};
    st_rd   = st_full + GW'(size[1:0] != 2'b00);
    st_blk  = {1'b0, size[SIZE_W-1:6]} + (SIZE_W-5)'(size[5:0] >= 6'd56);
    st_last = {st_blk, 4'hF};
  end

  always_comb begin
    pm = pad_mask(sz[1:0]);

    // Words formed without a read: pad word on a word boundary, the two
    // length words at the end, zero fill elsewhere.
    fill_word = '0;
    if (g == full_words)
      fill_word = pm.pad_word;
    else if (g == last_g - GW'(1))
      fill_word = 32'(sz >> 29);
    else if (g == last_g)
      fill_word = 32'({sz, 3'b000});

    if (g < full_words)
      mem_word = mem_read_data;
    else
      mem_word = (mem_read_data & pm.mask) | pm.pad_word;

    tag_block_last = (g[3:0] == 4'(WORDS_PER_BLOCK - 1));
    tag_msg_last   = (g == last_g);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      mem_addr       <= '0;
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_word_idx   <= '0;
      out_block_last <= 1'b0;
      out_msg_last   <= 1'b0;
      base           <= '0;
      sz             <= '0;
      g              <= '0;
      full_words     <= '0;
      rd_words       <= '0;
      last_g         <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            base       <= message_addr[ADDR_W-1:0];
            sz         <= size;
            full_words <= st_full;
            rd_words   <= st_rd;
            last_g     <= st_last;
            g          <= '0;
            busy       <= 1'b1;
            state      <= FETCH;
          end
        end

        FETCH: begin
          if (g < rd_words) begin
            mem_addr <= base + g[ADDR_W-1:0];
            state    <= WAIT;
          end else begin
            out_data       <= fill_word;
            out_word_idx   <= g[3:0];
            out_block_last <= tag_block_last;
            out_msg_last   <= tag_msg_last;
            out_valid      <= 1'b1;
            state          <= EMIT;
          end
        end

        WAIT: begin
          out_data       <= mem_word;
          out_word_idx   <= g[3:0];
          out_block_last <= tag_block_last;
          out_msg_last   <= tag_msg_last;
          out_valid      <= 1'b1;
          state          <= EMIT;
        end

        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (g == last_g) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              g     <= g + GW'(1);
              state <= FETCH;
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Self-checking bench for sha256_msg_padder. A byte-level SHA-256 padding
// model (message bytes, 0x80, zero fill, 64-bit length) provides expected
// words; the SRAM is a behavioural array read one cycle after mem_addr.
module tb_sha256_msg_padder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] message_addr = '0;
  logic [31:0] size = '0;
  logic        busy, done, mem_clk, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_read_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [3:0]  out_word_idx;
  logic        out_block_last, out_msg_last;

  logic [31:0] mem [65536];
  assign mem_read_data = mem[mem_addr];

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] ref64 [$];

  always #5 clk = ~clk;

  sha256_msg_padder #(.ADDR_W(16), .SIZE_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .message_addr(message_addr),
    .size(size), .busy(busy), .done(done), .mem_clk(mem_clk), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_read_data(mem_read_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_word_idx(out_word_idx),
    .out_block_last(out_block_last), .out_msg_last(out_msg_last)
  );

  // Reference: pad at byte level, then regroup into big-endian words.
  function automatic void build_exp(input logic [15:0] b, input logic [31:0] s,
                                    output logic [31:0] q[$]);
    logic [7:0]  by[$];
    logic [31:0] w;
    logic [15:0] a;
    logic [63:0] len;
    q = {};
    for (int unsigned i = 0; i < s; i++) begin
      a = b + 16'(i / 4);
      w = mem[a];
      by.push_back(w[8*(3-(i%4)) +: 8]);
    end
    by.push_back(8'h80);
    while (by.size() % 64 != 56) by.push_back(8'h00);
    len = 64'(s) * 64'd8;
    for (int k = 7; k >= 0; k--) by.push_back(len[8*k +: 8]);
    for (int i = 0; i < by.size(); i += 4)
      q.push_back({by[i], by[i+1], by[i+2], by[i+3]});
  endfunction

  // Runs one message and records every handshaken word with its tags.
  task automatic run_msg(input logic [15:0] b, input logic [31:0] s, input int stall_pct,
                         output logic [31:0] d[$], output logic [3:0] ix[$],
                         output logic bl[$], output logic ml[$],
                         output int cycles, output int dones, output int unstable,
                         output bit timeout);
    logic [37:0] cur, held;
    bit hs, stalled;
    d = {}; ix = {}; bl = {}; ml = {};
    cycles = 0; dones = 0; unstable = 0; timeout = 1'b1;
    @(negedge clk);
    message_addr = {16'h0000, b};
    size = s;
    start = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    cycles = 1;
    for (int k = 0; k < 20000; k++) begin
      out_ready = ($urandom_range(0, 99) >= stall_pct);
      cur = {out_data, out_word_idx, out_block_last, out_msg_last};
      hs = out_valid && out_ready;
      stalled = out_valid && !out_ready;
      held = cur;
      @(posedge clk); #1;
      cycles++;
      if (hs) begin
        d.push_back(cur[37:6]);
        ix.push_back(cur[5:2]);
        bl.push_back(cur[1]);
        ml.push_back(cur[0]);
      end
      if (stalled && !(out_valid &&
          {out_data, out_word_idx, out_block_last, out_msg_last} == held))
        unstable++;
      if (done) begin
        dones++;
        timeout = 1'b0;
        break;
      end
    end
    if (!timeout) begin
      repeat (3) begin
        @(posedge clk); #1;
        if (done) dones++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    n_checks++;
    if ({busy, done, out_valid, out_data, out_word_idx, out_block_last, out_msg_last,
         mem_addr, mem_we} !== '0)
      $display("FAIL reset_state: got busy=%b done=%b valid=%b data=%h idx=%0d bl=%b ml=%b addr=%h we=%b, want all 0",
               busy, done, out_valid, out_data, out_word_idx, out_block_last, out_msg_last, mem_addr, mem_we);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL idle_after_reset: valid=%b busy=%b, want 0 0", out_valid, busy);
    else n_pass++;
  endtask

  task automatic test_size0();
    logic [31:0] d[$], e[$]; logic [3:0] ix[$]; logic bl[$], ml[$];
    int cyc, dn, us; bit to;
    build_exp(16'h0040, 32'd0, e);
    run_msg(16'h0040, 32'd0, 0, d, ix, bl, ml, cyc, dn, us, to);
    n_checks++;
    if (to || d.size() != 16) $display("FAIL size0_len: got %0d words timeout=%0d, want 16", d.size(), to);
    else n_pass++;
    if (d.size() == 16) begin
      n_checks++;
      if (d[0] !== 32'h8000_0000) $display("FAIL size0_word0: got %h, want 80000000", d[0]);
      else n_pass++;
      for (int i = 0; i < 16; i++) begin
        n_checks++;
        if ({d[i], ix[i], bl[i], ml[i]} !== {e[i], 4'(i), i == 15, i == 15})
          $display("FAIL size0_word%0d: got %h/%0d/%b/%b, want %h/%0d/%b/%b",
                   i, d[i], ix[i], bl[i], ml[i], e[i], i, i == 15, i == 15);
        else n_pass++;
      end
    end
    n_checks++;
    if (cyc != 1 + 2 * 16) $display("FAIL size0_reads: got %0d cycles, want %0d (no reads)", cyc, 33);
    else n_pass++;
    n_checks++;
    if (dn != 1) $display("FAIL size0_done: got %0d done cycles, want 1", dn);
    else n_pass++;
  endtask

  task automatic test_size64();
    logic [31:0] d[$], e[$]; logic [3:0] ix[$]; logic bl[$], ml[$];
    int cyc, dn, us; bit to;
    build_exp(16'h0000, 32'd64, e);
    run_msg(16'h0000, 32'd64, 0, d, ix, bl, ml, cyc, dn, us, to);
    ref64 = d;
    n_checks++;
    if (to || d.size() != 32) $display("FAIL size64_len: got %0d words timeout=%0d, want 32", d.size(), to);
    else n_pass++;
    if (d.size() == 32) begin
      n_checks++;
      if ({d[0], d[1], d[16], d[30], d[31]} !==
          {32'h0123_4567, 32'h0246_8ACE, 32'h8000_0000, 32'h0, 32'h0000_0200})
        $display("FAIL size64_known: got w0=%h w1=%h w16=%h w30=%h w31=%h, want 01234567 02468ace 80000000 0 200",
                 d[0], d[1], d[16], d[30], d[31]);
      else n_pass++;
      for (int i = 0; i < 32; i++) begin
        n_checks++;
        if ({d[i], ix[i], bl[i], ml[i]} !== {e[i], 4'(i % 16), (i % 16) == 15, i == 31})
          $display("FAIL size64_word%0d: got %h/%0d/%b/%b, want %h/%0d/%b/%b",
                   i, d[i], ix[i], bl[i], ml[i], e[i], i % 16, (i % 16) == 15, i == 31);
        else n_pass++;
      end
    end
    n_checks++;
    if (cyc != 1 + 2 * 32 + 16) $display("FAIL size64_cycles: got %0d, want %0d", cyc, 81);
    else n_pass++;
  endtask

  task automatic test_boundaries();
    logic [31:0] d[$], e[$]; logic [3:0] ix[$]; logic bl[$], ml[$];
    int cyc, dn, us; bit to;
    logic [15:0] b;
    b = 16'h0200;
    build_exp(b, 32'd55, e);
    run_msg(b, 32'd55, 0, d, ix, bl, ml, cyc, dn, us, to);
    n_checks++;
    if (to || d.size() != 16) $display("FAIL size55_len: got %0d words, want 16", d.size());
    else n_pass++;
    if (d.size() == 16) begin
      n_checks++;
      if ({d[13], d[14], d[15]} !== {(mem[b + 16'd13] & 32'hFFFF_FF00) | 32'h80, 32'h0, 32'h0000_01B8})
        $display("FAIL size55_tail: got %h %h %h, want %h 0 1b8",
                 d[13], d[14], d[15], (mem[b + 16'd13] & 32'hFFFF_FF00) | 32'h80);
      else n_pass++;
      for (int i = 0; i < 16; i++) begin
        n_checks++;
        if (d[i] !== e[i]) $display("FAIL size55_word%0d: got %h, want %h", i, d[i], e[i]);
        else n_pass++;
      end
    end
    n_checks++;
    if (cyc - 1 - 2 * 16 != 14) $display("FAIL size55_reads: got %0d reads, want 14", cyc - 33);
    else n_pass++;

    b = 16'h0300;
    build_exp(b, 32'd56, e);
    run_msg(b, 32'd56, 0, d, ix, bl, ml, cyc, dn, us, to);
    n_checks++;
    if (to || d.size() != 32) $display("FAIL size56_len: got %0d words, want 32", d.size());
    else n_pass++;
    if (d.size() == 32) begin
      n_checks++;
      if ({d[14], d[31], ml[31], bl[15]} !== {32'h8000_0000, 32'h0000_01C0, 1'b1, 1'b1})
        $display("FAIL size56_tail: got w14=%h w31=%h ml=%b bl15=%b, want 80000000 1c0 1 1",
                 d[14], d[31], ml[31], bl[15]);
      else n_pass++;
      for (int i = 0; i < 32; i++) begin
        n_checks++;
        if (d[i] !== e[i]) $display("FAIL size56_word%0d: got %h, want %h", i, d[i], e[i]);
        else n_pass++;
      end
    end

    build_exp(b, 32'd57, e);
    run_msg(b, 32'd57, 0, d, ix, bl, ml, cyc, dn, us, to);
    n_checks++;
    if (to || d.size() != 32 || d[14] !== ((mem[b + 16'd14] & 32'hFF00_0000) | 32'h0080_0000))
      $display("FAIL size57_word14: got %0d words w14=%h, want 32 words w14=%h",
               d.size(), d.size() > 14 ? d[14] : 32'h0,
               (mem[b + 16'd14] & 32'hFF00_0000) | 32'h0080_0000);
    else n_pass++;
    for (int i = 0; i < d.size() && i < e.size(); i++) begin
      n_checks++;
      if (d[i] !== e[i]) $display("FAIL size57_word%0d: got %h, want %h", i, d[i], e[i]);
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    logic [31:0] d[$]; logic [3:0] ix[$]; logic bl[$], ml[$];
    int cyc, dn, us; bit to;
    run_msg(16'h0000, 32'd64, 50, d, ix, bl, ml, cyc, dn, us, to);
    n_checks++;
    if (to || d.size() != ref64.size()) $display("FAIL stall_len: got %0d, want %0d", d.size(), ref64.size());
    else n_pass++;
    for (int i = 0; i < d.size() && i < ref64.size(); i++) begin
      n_checks++;
      if ({d[i], ix[i], bl[i], ml[i]} !== {ref64[i], 4'(i % 16), (i % 16) == 15, i == 31})
        $display("FAIL stall_word%0d: got %h/%0d/%b/%b, want %h/%0d", i, d[i], ix[i], bl[i], ml[i], ref64[i], i % 16);
      else n_pass++;
    end
    n_checks++;
    if (us != 0) $display("FAIL stall_stable: got %0d unstable stalls, want 0", us);
    else n_pass++;
    n_checks++;
    if (dn != 1) $display("FAIL stall_done: got %0d done cycles, want 1", dn);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d[$], e[$]; logic [3:0] ix[$]; logic bl[$], ml[$];
    int cyc, dn, us, spurious; bit to, found;
    @(negedge clk);
    message_addr = '0; size = 32'd64; start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (out_valid && out_word_idx == 4'd5) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    n_checks++;
    if (!found) $display("FAIL midreset_reach: word 5 never presented, want reached");
    else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, out_valid, out_data, out_word_idx, out_block_last, out_msg_last, mem_addr} !== '0)
      $display("FAIL midreset_async: got busy=%b valid=%b data=%h idx=%0d addr=%h, want all 0",
               busy, out_valid, out_data, out_word_idx, mem_addr);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    spurious = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid || busy || done) spurious++;
    end
    n_checks++;
    if (spurious != 0) $display("FAIL midreset_quiet: got %0d active cycles, want 0", spurious);
    else n_pass++;
    build_exp(16'h0010, 32'd0, e);
    run_msg(16'h0010, 32'd0, 0, d, ix, bl, ml, cyc, dn, us, to);
    n_checks++;
    if (to || d.size() != 16 || dn != 1) $display("FAIL midreset_restart_len: got %0d words %0d dones, want 16 1", d.size(), dn);
    else n_pass++;
    for (int i = 0; i < d.size() && i < 16; i++) begin
      n_checks++;
      if ({d[i], ix[i], ml[i]} !== {e[i], 4'(i), i == 15})
        $display("FAIL midreset_word%0d: got %h/%0d/%b, want %h/%0d/%b", i, d[i], ix[i], ml[i], e[i], i, i == 15);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [31:0] d[$], e[$]; logic [3:0] ix[$]; logic bl[$], ml[$];
    int cyc, dn, us; bit to;
    logic [15:0] b;
    logic [31:0] s;
    for (int m = 0; m < 6; m++) begin
      b = (m == 0) ? 16'hFFFA : 16'($urandom);
      s = $urandom_range(0, 150);
      build_exp(b, s, e);
      run_msg(b, s, 30, d, ix, bl, ml, cyc, dn, us, to);
      n_checks++;
      if (to || d.size() != e.size() || dn != 1 || us != 0)
        $display("FAIL rand%0d_shape: base=%h size=%0d got %0d words %0d dones %0d unstable, want %0d 1 0",
                 m, b, s, d.size(), dn, us, e.size());
      else n_pass++;
      for (int i = 0; i < d.size() && i < e.size(); i++) begin
        n_checks++;
        if ({d[i], ix[i], bl[i], ml[i]} !== {e[i], 4'(i % 16), (i % 16) == 15, i == e.size() - 1})
          $display("FAIL rand%0d_word%0d: got %h/%0d/%b/%b, want %h/%0d", m, i, d[i], ix[i], bl[i], ml[i], e[i], i % 16);
        else n_pass++;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = $urandom;
    for (int i = 0; i < 16; i++) mem[i] = (32'h0123_4567 << i) | (32'h0123_4567 >> (32 - i));
    test_reset();
    test_size0();
    test_size64();
    test_boundaries();
    test_stall();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
